bcd_timer_counter: RTL and testbench

- Parametrised N-digit BCD up/down counter with debounced push-buttons and 7-segment outputs; successor to the two-digit ticket counter.
- Two modes, selected by sw:
  - Set mode (sw=1): the operator adjusts the value with the up/down keys. The value wraps within 0..MAX_VALUE.
  - Countdown mode (sw=0): the value decrements once per TICK_DIV clocks, stops at zero and flags expiry.
- Sits between the board buttons/switch and the 7-segment display pins.

---
 rtl/bcd_timer_counter_pkg.sv | 82 ++++++++
 rtl/bcd_timer_counter_key_debounce.sv | 46 ++++
 rtl/bcd_timer_counter.sv | 103 ++++++++++
 tb/tb_bcd_timer_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bcd_timer_counter_pkg.sv
// Shared types, segment table and BCD arithmetic helpers for the BCD timer/counter.
package bcd_timer_counter_pkg;

    localparam int unsigned MAX_DIGITS = 6;
    localparam int unsigned SEG_W      = 9;

    typedef logic [3:0]              bcd_digit_t;
    typedef logic [4*MAX_DIGITS-1:0] bcd_vec_t;

    // gfedcba patterns for digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [SEG_W-1:0] seg7_encode(input bcd_digit_t d);
        logic [SEG_W-1:0] s;
        s = '0;
        if (d <= 4'd9) begin
            s = {2'b00, SEG_TABLE[d]};
        end
        return s;
    endfunction

    // Increment the low n digits; carry is set when all n digits wrapped 9 -> 0.
    function automatic bcd_vec_t bcd_inc(input bcd_vec_t v, input int unsigned n,
                                         output logic carry);
        bcd_vec_t   r;
        bcd_digit_t d;
        logic       c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (i < n && c) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        carry = c;
        return r;
    endfunction

    // Decrement the low n digits; borrow is set when the input was zero.
    function automatic bcd_vec_t bcd_dec(input bcd_vec_t v, input int unsigned n,
                                         output logic borrow);
        bcd_vec_t   r;
        bcd_digit_t d;
        logic       b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (i < n && b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        borrow = b;
        return r;
    endfunction

    function automatic bcd_vec_t to_bcd(input int unsigned val);
        bcd_vec_t    r;
        int unsigned x;
        r = '0;
        x = val;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_timer_counter_key_debounce.sv
// Active-low key synchroniser plus saturating debounce counter; one press pulse per hold.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          key_meta_q, key_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (key_s_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end
            press_d = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_timer_counter.sv
// N-digit BCD set/countdown counter with debounced keys and 7-segment decode.
module bcd_timer_counter
    import bcd_timer_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 2,
    parameter int unsigned MAX_VALUE       = 30,
    parameter int unsigned TICK_DIV        = 12_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_up,
    input  logic                        key_dn,
    input  logic                        sw,
    output logic [4*NUM_DIGITS-1:0]     bcd,
    output logic [SEG_W*NUM_DIGITS-1:0] seg,
    output logic                        expired,
    output logic                        running
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BW-1:0] MAX_BCD = BW'(to_bcd(MAX_VALUE));

    logic          up_press, dn_press;
    logic          sw_meta_q, sw_s_q, sw_prev_q;
    logic [BW-1:0] value_q, value_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic [BW-1:0] inc_v, dec_v;
    logic          inc_c, dec_b, tick;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .key_n (key_up),
        .press (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .reset (reset),
        .key_n (key_dn),
        .press (dn_press)
    );

    always_comb begin
        value_d   = value_q;
        presc_d   = presc_q;
        expired_d = expired_q;
        inc_v     = BW'(bcd_inc(bcd_vec_t'(value_q), NUM_DIGITS, inc_c));
        dec_v     = BW'(bcd_dec(bcd_vec_t'(value_q), NUM_DIGITS, dec_b));
        tick      = (presc_q == PW'(TICK_DIV - 1));
        if (sw_s_q) begin
            presc_d   = '0;
            expired_d = 1'b0;
            if (up_press && !dn_press) begin
                value_d = (value_q == MAX_BCD || inc_c) ? '0 : inc_v;
            end else if (dn_press && !up_press) begin
                value_d = dec_b ? MAX_BCD : dec_v;
            end
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            // dec_b flags value == 0, which must hold rather than underflow
            if (tick && !dec_b) begin
                value_d = dec_v;
                if (dec_v == '0) begin
                    expired_d = 1'b1;
                end
            end
            if (sw_prev_q && dec_b) begin
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= 1'b1;
            sw_s_q    <= 1'b1;
            sw_prev_q <= 1'b1;
            value_q   <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            sw_meta_q <= sw;
            sw_s_q    <= sw_meta_q;
            sw_prev_q <= sw_s_q;
            value_q   <= value_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
        assign seg[SEG_W*i +: SEG_W] = seg7_encode(value_q[4*i +: 4]);
    end

    assign bcd     = value_q;
    assign expired = expired_q;
    assign running = ~sw_s_q & (value_q != '0);

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench for bcd_timer_counter: key presses, wrap, countdown, expiry and async reset.
module tb_bcd_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_up = 1'b1;
    logic        key_dn = 1'b1;
    logic        sw = 1'b1;
    logic [7:0]  bcd;
    logic [17:0] seg;
    logic        expired, running;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_timer_counter #(
        .NUM_DIGITS      (2),
        .MAX_VALUE       (30),
        .TICK_DIV        (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_up  (key_up),
        .key_dn  (key_dn),
        .sw      (sw),
        .bcd     (bcd),
        .seg     (seg),
        .expired (expired),
        .running (running)
    );

    typedef struct {
        logic       up;
        logic       dn;
        int         low;
        logic [7:0] exp_bcd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn, input int low);
        key_up = ~up;
        key_dn = ~dn;
        cyc(low);
        key_up = 1'b1;
        key_dn = 1'b1;
        cyc(6);
    endtask

    function automatic logic [7:0] to_bcd8(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    initial begin
        vecs.push_back('{1'b1, 1'b0, 20, 8'h01});
        vecs.push_back('{1'b1, 1'b0, 3,  8'h01});
        for (int k = 2; k <= 30; k++) vecs.push_back('{1'b1, 1'b0, 6, to_bcd8(k)});
        vecs.push_back('{1'b1, 1'b0, 6, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 6, 8'h30});
        vecs.push_back('{1'b1, 1'b1, 6, 8'h30});
        for (int k = 1; k <= 18; k++) vecs.push_back('{1'b0, 1'b1, 6, to_bcd8(30 - k)});

        // power-up
        cyc(3);
        chk("reset_bcd", 32'(bcd), 32'h00);
        reset = 1'b1;
        cyc(1);
        chk("pwr_bcd", 32'(bcd), 32'h00);
        chk("pwr_seg", 32'(seg), 32'({9'h03F, 9'h03F}));
        chk("pwr_expired", 32'(expired), 32'd0);
        chk("pwr_running", 32'(running), 32'd0);

        // set-mode key table
        foreach (vecs[i]) begin
            press(vecs[i].up, vecs[i].dn, vecs[i].low);
            chk($sformatf("set_vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            if (i == 0) chk("set_vec0_seg", 32'(seg), 32'({9'h03F, 9'h006}));
        end

        // countdown from 12 with borrow
        sw = 1'b0;
        cyc(11);
        chk("cd_pre_tick", 32'(bcd), 32'h12);
        chk("cd_running", 32'(running), 32'd1);
        cyc(1);
        chk("cd_11", 32'(bcd), 32'h11);
        cyc(10);
        chk("cd_10", 32'(bcd), 32'h10);
        cyc(10);
        chk("cd_09", 32'(bcd), 32'h09);
        chk("cd_09_seg", 32'(seg), 32'({9'h03F, 9'h06F}));

        // expiry
        cyc(80);
        chk("cd_01", 32'(bcd), 32'h01);
        chk("cd_01_expired", 32'(expired), 32'd0);
        cyc(10);
        chk("cd_00", 32'(bcd), 32'h00);
        chk("cd_00_expired", 32'(expired), 32'd1);
        chk("cd_00_running", 32'(running), 32'd0);
        cyc(50);
        chk("cd_hold_bcd", 32'(bcd), 32'h00);
        chk("cd_hold_expired", 32'(expired), 32'd1);
        sw = 1'b1;
        cyc(3);
        chk("set_clears_expired", 32'(expired), 32'd0);

        // async reset mid-countdown
        for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 6);
        chk("rst_setup_06", 32'(bcd), 32'h06);
        sw = 1'b0;
        cyc(12);
        chk("rst_setup_05", 32'(bcd), 32'h05);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(bcd), 32'h00);
        chk("async_rst_expired", 32'(expired), 32'd0);
        chk("async_rst_seg", 32'(seg), 32'({9'h03F, 9'h03F}));
        #1 reset = 1'b1;
        cyc(1);
        chk("post_rst_expired_early", 32'(expired), 32'd0);
        cyc(2);
        chk("post_rst_expired", 32'(expired), 32'd1);
        cyc(12);
        chk("post_rst_hold", 32'(bcd), 32'h00);
        chk("post_rst_running", 32'(running), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
